// File: rtl/tlv2548_spi_responder.sv
// TLV2548 SPI responder: SPI slave model of an 8-channel 12-bit ADC.
// Decodes 16-bit command frames, models conversion latency, a result
// FIFO and the active-low end-of-conversion interrupt.
module tlv2548_spi_responder #(
    parameter int P_CONV_CYCLES = 16,
    parameter int P_FIFO_DEPTH  = 8,
    parameter int P_FIFO_TRIG   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_spi_cs,
    input  logic        i_spi_sck,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic        o_adc_int,
    input  logic [95:0] i_ch_data,
    output logic [11:0] o_cfr,
    output logic [3:0]  o_cmd,
    output logic        o_cmd_valid,
    output logic [2:0]  o_err
);
    localparam int PW   = $clog2(P_FIFO_DEPTH);
    localparam int CNTW = $clog2(P_FIFO_DEPTH + 1);
    localparam int CCW  = $clog2(P_CONV_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_EXEC} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cs_sync_q, cs_sync_d;
    logic [1:0]      sck_sync_q, sck_sync_d;
    logic [1:0]      mosi_sync_q, mosi_sync_d;
    logic            cs_prev_q, cs_prev_d;
    logic            sck_prev_q, sck_prev_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [15:0]     rx_sr_q, rx_sr_d;
    logic [15:0]     tx_sr_q, tx_sr_d;
    logic [11:0]     cfr_q, cfr_d;
    logic [3:0]      cmd_q, cmd_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [2:0]      err_q, err_d;
    logic            conv_busy_q, conv_busy_d;
    logic [CCW-1:0]  conv_cnt_q, conv_cnt_d;
    logic [11:0]     conv_val_q, conv_val_d;
    logic [11:0]     mem_q [P_FIFO_DEPTH];
    logic [11:0]     mem_d [P_FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            adc_int_q, adc_int_d;

    logic cs_s, sck_s, mosi_s;
    logic cs_fall, cs_rise, sck_rise, sck_fall;
    logic push, pop, pop_eff, push_ok;

    assign cs_s     = cs_sync_q[1];
    assign sck_s    = sck_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;

    // Next-state logic: synchronizers, frame FSM, converter and FIFO
    always_comb begin
        state_d     = state_q;
        cs_sync_d   = {cs_sync_q[0], i_spi_cs};
        sck_sync_d  = {sck_sync_q[0], i_spi_sck};
        mosi_sync_d = {mosi_sync_q[0], i_spi_mosi};
        cs_prev_d   = cs_s;
        sck_prev_d  = sck_s;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        cfr_d       = cfr_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        err_d       = 3'b000;
        conv_busy_d = conv_busy_q;
        conv_cnt_d  = conv_cnt_q;
        conv_val_d  = conv_val_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        push        = 1'b0;
        pop         = 1'b0;

        // Running conversion; a new one can only start while idle
        if (conv_busy_q) begin
            if (conv_cnt_q == CCW'(P_CONV_CYCLES - 1)) begin
                push        = 1'b1;
                conv_busy_d = 1'b0;
            end else begin
                conv_cnt_d = conv_cnt_q + CCW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                tx_sr_d = 16'h0000;
                if (cs_fall) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = 5'd0;
                    rx_sr_d   = 16'h0000;
                    // MISO word is the FIFO head captured at frame start
                    tx_sr_d   = (count_q != '0) ? {mem_q[rd_ptr_q], 4'b0000} : 16'h0000;
                end
            end
            S_SHIFT: begin
                if (cs_rise) begin
                    state_d = S_EXEC;
                    tx_sr_d = 16'h0000;
                end else begin
                    if (sck_rise && bit_cnt_q < 5'd16) begin
                        rx_sr_d   = {rx_sr_q[14:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                    if (sck_fall)
                        tx_sr_d = {tx_sr_q[14:0], 1'b0};
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                if (bit_cnt_q == 5'd16) begin
                    cmd_d       = rx_sr_q[15:12];
                    cmd_valid_d = 1'b1;
                    if (!rx_sr_q[15]) begin
                        if (conv_busy_q) begin
                            err_d[1] = 1'b1;
                        end else begin
                            conv_busy_d = 1'b1;
                            conv_cnt_d  = '0;
                            conv_val_d  = i_ch_data[12*int'(rx_sr_q[14:12]) +: 12];
                        end
                    end else if (rx_sr_q[15:12] == 4'hA) begin
                        cfr_d = rx_sr_q[11:0];
                    end else if (rx_sr_q[15:12] == 4'hE) begin
                        pop = 1'b1;
                    end
                end else begin
                    err_d[0] = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // FIFO: a pop in the same cycle frees the slot a full push needs
        pop_eff = pop && (count_q != '0);
        push_ok = push && ((count_q != CNTW'(P_FIFO_DEPTH)) || pop_eff);
        if (push && !push_ok)
            err_d[2] = 1'b1;
        if (push_ok) begin
            mem_d[wr_ptr_q] = conv_val_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_eff)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok && !pop_eff)
            count_d = count_q + CNTW'(1);
        else if (!push_ok && pop_eff)
            count_d = count_q - CNTW'(1);

        adc_int_d = !(count_q >= CNTW'(P_FIFO_TRIG));
    end

    // State registers; CS sync resets low so a CS held low across reset
    // produces no falling edge and the interrupted frame is discarded
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cs_sync_q   <= 2'b00;
            sck_sync_q  <= 2'b00;
            mosi_sync_q <= 2'b00;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
            bit_cnt_q   <= 5'd0;
            rx_sr_q     <= 16'h0000;
            tx_sr_q     <= 16'h0000;
            cfr_q       <= 12'h000;
            cmd_q       <= 4'h0;
            cmd_valid_q <= 1'b0;
            err_q       <= 3'b000;
            conv_busy_q <= 1'b0;
            conv_cnt_q  <= '0;
            conv_val_q  <= 12'h000;
            for (int i = 0; i < P_FIFO_DEPTH; i++)
                mem_q[i] <= 12'h000;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            adc_int_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_prev_d;
            sck_prev_q  <= sck_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            cfr_q       <= cfr_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
            conv_busy_q <= conv_busy_d;
            conv_cnt_q  <= conv_cnt_d;
            conv_val_q  <= conv_val_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            adc_int_q   <= adc_int_d;
        end
    end

    assign o_spi_miso  = tx_sr_q[15];
    assign o_adc_int   = adc_int_q;
    assign o_cfr       = cfr_q;
    assign o_cmd       = cmd_q;
    assign o_cmd_valid = cmd_valid_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_tlv2548_spi_responder.sv
// Bench for tlv2548_spi_responder: 100 MHz clock, 10 MHz SPI master,
// transaction-level ADC model (queue FIFO, CFR, pending conversion).
module tb_tlv2548_spi_responder;
    localparam int P_CONV = 300;  // long enough for a back-to-back convert to hit busy

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic        o_spi_miso, o_adc_int, o_cmd_valid;
    logic [95:0] ch_data;
    logic [11:0] o_cfr;
    logic [3:0]  o_cmd;
    logic [2:0]  o_err;

    tlv2548_spi_responder #(.P_CONV_CYCLES(P_CONV), .P_FIFO_DEPTH(8), .P_FIFO_TRIG(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_spi_cs(cs), .i_spi_sck(sck), .i_spi_mosi(mosi),
        .o_spi_miso(o_spi_miso), .o_adc_int(o_adc_int), .i_ch_data(ch_data),
        .o_cfr(o_cfr), .o_cmd(o_cmd), .o_cmd_valid(o_cmd_valid), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    // model state
    logic [11:0] mq[$];
    logic [11:0] m_cfr = 12'h000;
    logic [3:0]  m_cmd = 4'h0;
    bit          m_pend = 1'b0;
    logic [11:0] m_pval = 12'h000;
    int e_cmdv = 0, e_err0 = 0, e_err1 = 0, e_err2 = 0;
    // observed pulse counts
    int n_cmdv = 0, n_err0 = 0, n_err1 = 0, n_err2 = 0;
    bit quiet = 1'b0;
    logic [15:0] rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pulse monitor plus per-cycle comparison against the model while idle
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_cmd_valid === 1'b1) n_cmdv++;
            if (o_err[0] === 1'b1) n_err0++;
            if (o_err[1] === 1'b1) n_err1++;
            if (o_err[2] === 1'b1) n_err2++;
            if (quiet) begin
                chk("cyc_cfr", 32'(o_cfr), 32'(m_cfr));
                chk("cyc_cmd", 32'(o_cmd), 32'(m_cmd));
                chk("cyc_int", 32'(o_adc_int), (mq.size() >= 8) ? 32'd0 : 32'd1);
                chk("cyc_pulses", {28'd0, o_cmd_valid, o_err}, 32'd0);
                if (cs) chk("cyc_miso_idle", 32'(o_spi_miso), 32'd0);
            end
        end
    end

    function automatic void model_exec(input logic [15:0] w, input int nbits);
        if (nbits < 16) begin
            e_err0++;
        end else begin
            m_cmd = w[15:12];
            e_cmdv++;
            if (!w[15]) begin
                if (m_pend) e_err1++;
                else begin
                    m_pend = 1'b1;
                    m_pval = 12'h100 + 12'(w[14:12]);
                end
            end else if (w[15:12] == 4'hA) begin
                m_cfr = w[11:0];
            end else if (w[15:12] == 4'hE) begin
                if (mq.size() > 0) void'(mq.pop_front());
            end
        end
    endfunction

    function automatic void model_retire();
        if (m_pend) begin
            if (mq.size() >= 8) e_err2++;
            else mq.push_back(m_pval);
            m_pend = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_cfr = 12'h000;
        m_cmd = 4'h0;
        m_pend = 1'b0;
    endfunction

    task automatic shift_bits(input logic [15:0] w, input int from, input int to,
                              inout logic [15:0] cap);
        for (int i = from; i < to; i++) begin
            mosi = w[15-i];
            #50;
            cap = {cap[14:0], o_spi_miso};
            sck = 1'b1;
            #50;
            sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] w, input int nbits, input int settle,
                         input bit do_chk, output logic [15:0] cap);
        logic [15:0] exp_rd;
        quiet  = 1'b0;
        exp_rd = (mq.size() > 0) ? {mq[0], 4'h0} : 16'h0000;
        cap    = 16'h0000;
        cs     = 1'b0;
        #50;
        shift_bits(w, 0, nbits, cap);
        #50;
        cs   = 1'b1;
        mosi = 1'b0;
        model_exec(w, nbits);
        if (nbits == 16) chk("miso_word", 32'(cap), 32'(exp_rd));
        repeat (settle) @(posedge clk);
        #1;
        if (do_chk) begin
            model_retire();
            chk("cnt_cmd_valid", n_cmdv, e_cmdv);
            chk("cnt_err0", n_err0, e_err0);
            chk("cnt_err1", n_err1, e_err1);
            chk("cnt_err2", n_err2, e_err2);
            quiet = 1'b1;
        end
    endtask

    initial begin
        for (int n = 0; n < 8; n++) ch_data[12*n +: 12] = 12'h100 + 12'(n);
        #3;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_int", 32'(o_adc_int), 32'd1);
        chk("rst_miso", 32'(o_spi_miso), 32'd0);
        chk("rst_cfr", 32'(o_cfr), 32'd0);
        chk("rst_cmd", 32'(o_cmd), 32'd0);
        chk("rst_pulses", {28'd0, o_cmd_valid, o_err}, 32'd0);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_no_cmd_valid", n_cmdv, 0);

        // CFR write
        frame(16'hA0C0, 16, 12, 1'b1, rd);
        chk("lit_cfr_0c0", 32'(o_cfr), 32'h0C0);
        chk("lit_cmd_a", 32'(o_cmd), 32'hA);
        chk("lit_one_cmd_valid", n_cmdv, 1);

        // fill FIFO with ch0..ch7
        for (int c = 0; c < 8; c++)
            frame(16'(c) << 12, 16, P_CONV + 40, 1'b1, rd);
        chk("lit_int_full", 32'(o_adc_int), 32'd0);

        // drain
        for (int r = 0; r < 8; r++) begin
            frame(16'hE000, 16, 12, 1'b1, rd);
            if (r == 0) begin
                chk("lit_first_read", 32'(rd[15:4]), 32'h100);
                chk("lit_int_after_pop", 32'(o_adc_int), 32'd1);
            end
            if (r == 7) chk("lit_last_read", 32'(rd[15:4]), 32'h107);
        end

        // convert while busy
        frame(16'h0000, 16, 5, 1'b0, rd);
        frame(16'h1000, 16, P_CONV + 40, 1'b1, rd);
        chk("lit_busy_err", n_err1, 1);
        frame(16'hE000, 16, 12, 1'b1, rd);
        chk("lit_busy_read_ch0", 32'(rd), 32'h1000);

        // overflow: 9 converts, then 9 reads
        for (int c = 0; c < 9; c++)
            frame(16'(c % 8) << 12, 16, P_CONV + 40, 1'b1, rd);
        chk("lit_overflow_err", n_err2, 1);
        for (int r = 0; r < 9; r++) begin
            frame(16'hE000, 16, 12, 1'b1, rd);
            if (r == 0) chk("lit_ovf_read0", 32'(rd[15:4]), 32'h100);
        end
        chk("lit_read_empty", 32'(rd), 32'h0000);

        // short frame leaves CFR and FIFO alone
        frame(16'hA055, 16, 12, 1'b1, rd);
        frame(16'h3000, 16, P_CONV + 40, 1'b1, rd);
        frame(16'hA0FF, 10, 12, 1'b1, rd);
        chk("lit_short_err", n_err0, 1);
        chk("lit_short_cfr", 32'(o_cfr), 32'h055);
        frame(16'hE000, 16, 12, 1'b1, rd);
        chk("lit_short_fifo", 32'(rd[15:4]), 32'h103);

        // other command and pop on empty
        frame(16'hC123, 16, 12, 1'b1, rd);
        chk("lit_cmd_c", 32'(o_cmd), 32'hC);
        frame(16'hE000, 16, 12, 1'b1, rd);

        // async reset mid-frame
        frame(16'h5000, 16, P_CONV + 40, 1'b1, rd);
        quiet = 1'b0;
        rd = 16'h0000;
        cs = 1'b0;
        #50;
        shift_bits(16'hA7FF, 0, 6, rd);
        rst_n = 1'b0;
        model_reset();
        #30;
        rst_n = 1'b1;
        shift_bits(16'hA7FF, 6, 16, rd);
        #50;
        cs = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("rstmid_cfr", 32'(o_cfr), 32'h000);
        chk("rstmid_int", 32'(o_adc_int), 32'd1);
        chk("rstmid_cmdv", n_cmdv, e_cmdv);
        chk("rstmid_err0", n_err0, e_err0);
        quiet = 1'b1;
        frame(16'hA123, 16, 12, 1'b1, rd);
        chk("lit_cfr_after_reset", 32'(o_cfr), 32'h123);
        chk("lit_miso_empty_after_reset", 32'(rd), 32'h0000);

        quiet = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
